elevator_call_dispatcher: RTL

Request-side companion to the elevator car controller: collects floor calls, runs a SCAN (collective up/down) schedule, and drives the target floor into the car controller. The controller moves the car toward `requested_floor` and reports the car position back on `car_floor`. The dispatcher tracks pending calls as a bitmap and opens the door for a fixed dwell period at each served floor. It clears each call when the car arrives at that floor.

---
 rtl/elevator_call_dispatcher.sv | 120 ++++++++++++
 1 files changed

// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher: SCAN call scheduler driving target floor and door dwell for the car controller
module elevator_call_dispatcher #(
  parameter int FLOOR_COUNT  = 50,
  parameter int FLOOR_W      = 6,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [FLOOR_W-1:0]     req_floor,
  input  logic [FLOOR_W-1:0]     car_floor,
  output logic [FLOOR_W-1:0]     requested_floor,
  output logic                   target_valid,
  output logic                   door_open,
  output logic [1:0]             direction,
  output logic [FLOOR_COUNT-1:0] pending,
  output logic                   req_err
);
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL = CNT_W'(DWELL_CYCLES);
  localparam logic [FLOOR_W-1:0] LAST = FLOOR_W'(FLOOR_COUNT - 1);
  localparam logic [1:0] UP = 2'b01;
  localparam logic [1:0] DN = 2'b10;
  typedef enum logic [1:0] {IDLE, SERVE, DWELL_ST} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] dir_n;
  logic [FLOOR_W-1:0] tgt_n, up_f, dn_f;
  logic [FLOOR_COUNT-1:0] set_m, clr_m;
  logic up_ok, dn_ok, car_ok, req_ok, here, reload, go_up;
  always_comb begin
    up_ok = 1'b0;
    dn_ok = 1'b0;
    up_f = '0;
    dn_f = '0;
    for (int i = FLOOR_COUNT - 1; i >= 0; i--)
      if (pending[i] && FLOOR_W'(i) > car_floor) begin
        up_ok = 1'b1;
        up_f = FLOOR_W'(i);
      end
    for (int i = 0; i < FLOOR_COUNT; i++)
      if (pending[i] && FLOOR_W'(i) < car_floor) begin
        dn_ok = 1'b1;
        dn_f = FLOOR_W'(i);
      end
  end
  assign car_ok = car_floor <= LAST;
  assign req_ok = req_valid && req_floor <= LAST;
  assign here   = car_ok && pending[car_floor];
  // a call for the floor the door is open at just extends the stop
  assign reload = state == DWELL_ST && req_ok && req_floor == car_floor;
  assign set_m  = req_ok && !reload ? FLOOR_COUNT'(1) << req_floor : '0;
  // an idle stop has no heading, so it leaves upward first like IDLE does
  assign go_up  = direction == DN ? !dn_ok && up_ok : up_ok;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dir_n = direction;
    tgt_n = requested_floor;
    clr_m = '0;
    case (state)
      IDLE: begin
        tgt_n = car_floor;
        dir_n = 2'b00;
        if (here) begin
          state_n = DWELL_ST;
          cnt_n = DWELL;
          clr_m = FLOOR_COUNT'(1) << car_floor;
        end else if (up_ok || dn_ok) begin
          state_n = SERVE;
          dir_n = up_ok ? UP : DN;
          tgt_n = up_ok ? up_f : dn_f;
        end
      end
      SERVE: begin
        if (car_floor == requested_floor) begin
          state_n = DWELL_ST;
          cnt_n = DWELL;
          clr_m = FLOOR_COUNT'(1) << requested_floor;
        end else if (direction == UP ? up_ok : dn_ok) begin
          tgt_n = direction == UP ? up_f : dn_f;
        end else begin
          state_n = IDLE;
          dir_n = 2'b00;
          tgt_n = car_floor;
        end
      end
      DWELL_ST: begin
        if (reload) cnt_n = DWELL;
        else if (cnt > CNT_W'(1)) cnt_n = cnt - 1'b1;
        else begin
          state_n = up_ok || dn_ok ? SERVE : IDLE;
          dir_n = go_up ? UP : dn_ok ? DN : 2'b00;
          tgt_n = go_up ? up_f : dn_ok ? dn_f : car_floor;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      direction <= '0;
      requested_floor <= '0;
      pending <= '0;
      req_err <= 1'b0;
      target_valid <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      direction <= dir_n;
      requested_floor <= tgt_n;
      pending <= (pending | set_m) & ~clr_m;
      req_err <= req_valid && req_floor > LAST;
      target_valid <= state_n == SERVE;
      door_open <= state_n == DWELL_ST;
    end
endmodule
